muldiv_seq: RTL and testbench



---
 rtl/muldiv_pkg.sv | 40 ++++
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_seq.sv | 186 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared width, RV32M funct3 encodings, sequencer states,
//                special-case results and operand signedness helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] DIV0_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] OVF_Q  = 32'h8000_0000;

    function automatic logic rs1_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic rs2_signed(input logic [2:0] op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : One combinational iteration: shift-add on {product-high,
//                multiplier} or restoring trial-subtract on {remainder, quotient}.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            i_is_div,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_opnd,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    always_comb begin
        w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : '0);
        // 33-bit partial remainder; its low 32 bits of the difference are exact when it fits
        w_shift = {i_hi, i_lo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, i_opnd});
        w_diff  = w_shift[XLEN-1:0] - i_opnd;
        o_hi    = w_sum[XLEN:1];
        o_lo    = {w_sum[0], i_lo[XLEN-1:1]};
        if (i_is_div) begin
            o_hi = w_ge ? w_diff : w_shift[XLEN-1:0];
            o_lo = {i_lo[XLEN-2:0], w_ge};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_seq
//  Description : Iterative RV32M multiply/divide sequencer with pipeline stall.
//                MULDIV_FAST_MUL_EN selects single-cycle multiplies.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_ex,
    input  logic [2:0]      md_op_ex,
    input  logic [XLEN-1:0] rD1_ex,
    input  logic [XLEN-1:0] rD2_ex,
    input  logic            flush,
    output logic            stall_req,
    output logic            busy,
    output logic            md_valid,
    output logic [XLEN-1:0] md_result
);
    import muldiv_pkg::*;

    state_t            r_state;
    state_t            w_next;
    logic [4:0]        r_cnt;
    logic [2:0]        r_op;
    logic              r_neg1;
    logic              r_neg2;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_opnd;
    logic [XLEN-1:0]   r_result;

    logic              w_accept;
    logic              w_neg1;
    logic              w_neg2;
    logic [XLEN-1:0]   w_abs1;
    logic [XLEN-1:0]   w_abs2;
    logic              w_div0;
    logic              w_ovf;
    logic              w_fast;
    logic [XLEN-1:0]   w_fast_res;
    logic              w_special;
    logic [XLEN-1:0]   w_spec_res;
    logic [XLEN-1:0]   w_step_hi;
    logic [XLEN-1:0]   w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign w_accept = start_ex & ~flush;
    assign w_neg1   = rs1_signed(md_op_ex) & rD1_ex[XLEN-1];
    assign w_neg2   = rs2_signed(md_op_ex) & rD2_ex[XLEN-1];
    assign w_abs1   = w_neg1 ? -rD1_ex : rD1_ex;
    assign w_abs2   = w_neg2 ? -rD2_ex : rD2_ex;
    assign w_div0   = md_op_ex[2] & (rD2_ex == '0);
    // only signed div/rem (funct3 bit0 clear) can overflow
    assign w_ovf    = md_op_ex[2] & ~md_op_ex[0] & (rD1_ex == OVF_Q) & (rD2_ex == '1);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] w_fprod;
    logic                     w_unused_fprod;
    assign w_fprod        = $signed({rs1_signed(md_op_ex) & rD1_ex[XLEN-1], rD1_ex}) *
                            $signed({rs2_signed(md_op_ex) & rD2_ex[XLEN-1], rD2_ex});
    assign w_unused_fprod = ^w_fprod[2*XLEN+1:2*XLEN];
    assign w_fast         = ~md_op_ex[2];
    assign w_fast_res     = (md_op_ex == MD_MUL) ? w_fprod[XLEN-1:0] : w_fprod[2*XLEN-1:XLEN];
`else
    assign w_fast         = 1'b0;
    assign w_fast_res     = '0;
`endif

    assign w_special = w_div0 | w_ovf | w_fast;

    always_comb begin
        w_spec_res = md_op_ex[1] ? '0 : OVF_Q;
        if (w_fast) begin
            w_spec_res = w_fast_res;
        end else if (w_div0) begin
            w_spec_res = md_op_ex[1] ? rD1_ex : DIV0_Q;
        end
    end

    muldiv_step u_step (
        .i_is_div (r_op[2]),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_opnd   (r_opnd),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    // sign fix-up applied to the outcome of the last step
    always_comb begin
        w_prod  = {w_step_hi, w_step_lo};
        w_prod  = (r_neg1 ^ r_neg2) ? -w_prod : w_prod;
        w_quo   = (r_neg1 ^ r_neg2) ? -w_step_lo : w_step_lo;
        w_rem   = r_neg1 ? -w_step_hi : w_step_hi;
        case (r_op)
            MD_MUL:          w_final = w_prod[XLEN-1:0];
            MD_DIV, MD_DIVU: w_final = w_quo;
            MD_REM, MD_REMU: w_final = w_rem;
            default:         w_final = w_prod[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_special ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    w_next = IDLE;
                end else if (r_cnt == 5'd31) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        stall_req = ~rst & (((r_state == IDLE) & w_accept) | (r_state == CALC));
        busy      = (r_state == CALC);
        md_valid  = (r_state == DONE) & ~flush;
        md_result = r_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_op     <= MD_MUL;
            r_neg1   <= 1'b0;
            r_neg2   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt  <= '0;
                        r_op   <= md_op_ex;
                        r_neg1 <= w_neg1;
                        r_neg2 <= w_neg2;
                        r_hi   <= '0;
                        r_lo   <= md_op_ex[2] ? w_abs1 : w_abs2;
                        r_opnd <= md_op_ex[2] ? w_abs2 : w_abs1;
                        if (w_special) begin
                            r_result <= w_spec_res;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        r_hi  <= w_step_hi;
                        r_lo  <= w_step_lo;
                        r_cnt <= r_cnt + 5'd1;
                        if (r_cnt == 5'd31) begin
                            r_result <= w_final;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_seq
//  Description : Scoreboard bench for muldiv_seq (results, latency, stall,
//                flush, reset). Honours MULDIV_FAST_MUL_EN for multiply latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;
    import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_ex;
    logic [2:0]  md_op_ex;
    logic [31:0] rD1_ex;
    logic [31:0] rD2_ex;
    logic        flush;
    logic        stall_req;
    logic        busy;
    logic        md_valid;
    logic [31:0] md_result;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] last_result = 32'h0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .start_ex  (start_ex),
        .md_op_ex  (md_op_ex),
        .rD1_ex    (rD1_ex),
        .rD2_ex    (rD2_ex),
        .flush     (flush),
        .stall_req (stall_req),
        .busy      (busy),
        .md_valid  (md_valid),
        .md_result (md_result)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic        ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        model = 32'h0;
        case (op)
            MD_MUL:    begin p = sa * sb; model = p[31:0];  end
            MD_MULH:   begin p = sa * sb; model = p[63:32]; end
            MD_MULHSU: begin p = sa * ub; model = p[63:32]; end
            MD_MULHU:  begin p = ua * ub; model = p[63:32]; end
            MD_DIV: begin
                if (b == 0)   model = 32'hFFFF_FFFF;
                else if (ovf) model = 32'h8000_0000;
                else begin p = sa / sb; model = p[31:0]; end
            end
            MD_DIVU: begin
                if (b == 0) model = 32'hFFFF_FFFF;
                else begin p = ua / ub; model = p[31:0]; end
            end
            MD_REM: begin
                if (b == 0)   model = a;
                else if (ovf) model = 32'h0;
                else begin p = sa % sb; model = p[31:0]; end
            end
            default: begin
                if (b == 0) model = a;
                else begin p = ua % ub; model = p[31:0]; end
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drive one op in the low clock phase, wait (bounded) for md_valid, score it.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        int          lat;
        int          stalls;
        bit          got;
        logic [31:0] exp;
        md_op_ex = op;
        rD1_ex   = a;
        rD2_ex   = b;
        start_ex = 1'b1;
        sb_q.push_back(model(op, a, b));
        lat    = 0;
        stalls = 0;
        got    = 1'b0;
        #1;
        while (!got && lat < 60) begin
            if (stall_req) stalls++;
            @(negedge clk);
            #1;
            lat++;
            if (md_valid) got = 1'b1;
        end
        start_ex = 1'b0;
        if (!got) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end else begin
            exp = sb_q.pop_front();
            last_result = exp;
            check(tag, md_result, exp);
            check({tag, "_lat"}, lat, exp_lat(op, a, b));
            check({tag, "_stall"}, stalls, exp_lat(op, a, b));
        end
        @(negedge clk);
        #1;
        check({tag, "_pulse"}, {31'd0, md_valid}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        rst      = 1'b1;
        start_ex = 1'b1;
        flush    = 1'b0;
        md_op_ex = MD_MUL;
        rD1_ex   = 32'd5;
        rD2_ex   = 32'd3;
        @(negedge clk);
        #1;
        check("rst_stall_held_start", {31'd0, stall_req}, 32'd0);
        start_ex = 1'b0;
        @(negedge clk);
        #1;
        check("rst_busy",   {31'd0, busy},     32'd0);
        check("rst_valid",  {31'd0, md_valid}, 32'd0);
        check("rst_result", md_result,         32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        run_op(MD_MUL,    32'd7,          32'hFFFF_FFFD, "mul");
        run_op(MD_MULH,   32'h8000_0000,  32'h8000_0000, "mulh");
        run_op(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, "mulhu");
        run_op(MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         "mulhsu");
        run_op(MD_DIV,    32'hFFFF_FFF9,  32'd2,         "div");
        run_op(MD_REM,    32'hFFFF_FFF9,  32'd2,         "rem");
        run_op(MD_DIVU,   32'd100,        32'd7,         "divu");
        run_op(MD_REMU,   32'd100,        32'd7,         "remu");
        run_op(MD_DIVU,   32'd5,          32'd0,         "divu_by0");
        run_op(MD_REM,    32'd5,          32'd0,         "rem_by0");
        run_op(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, "div_ovf");
        run_op(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, "rem_ovf");

        // flush on CALC step 10: no result, no strobe, md_result retained
        md_op_ex = MD_DIVU;
        rD1_ex   = 32'd100;
        rD2_ex   = 32'd7;
        start_ex = 1'b1;
        repeat (11) @(negedge clk);
        #1;
        check("flush_busy_before", {31'd0, busy}, 32'd1);
        flush    = 1'b1;
        start_ex = 1'b0;
        @(negedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy",   {31'd0, busy},     32'd0);
        check("flush_valid",  {31'd0, md_valid}, 32'd0);
        check("flush_result", md_result,         last_result);
        v = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (md_valid) v++;
        end
        check("flush_no_valid", v, 32'd0);
        run_op(MD_DIV, 32'd9, 32'd3, "div_after_flush");

        // reset mid-CALC with start held through and after reset
        md_op_ex = MD_DIV;
        rD1_ex   = 32'd9;
        rD2_ex   = 32'd3;
        start_ex = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("midrst_busy_before", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_stall_forced", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        #1;
        check("midrst_busy",   {31'd0, busy},      32'd0);
        check("midrst_valid",  {31'd0, md_valid},  32'd0);
        check("midrst_stall",  {31'd0, stall_req}, 32'd0);
        check("midrst_result", md_result,          32'd0);
        rst = 1'b0;
        run_op(MD_DIV, 32'd9, 32'd3, "div_held_start");

        for (int i = 0; i < 10; i++) begin
            logic [2:0]  op;
            logic [31:0] a;
            logic [31:0] b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = (i % 4 == 3) ? 32'd0 : $urandom;
            if (i % 5 == 1) b = b & 32'h0000_00FF;
            run_op(op, a, b, "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
